// File: rtl/lc3b_types.sv
// Shared types and default widths for the LC-3b memory subsystem.
package lc3b_types;

   localparam int ADDR_WIDTH_DEF = 16;
   localparam int LINE_WIDTH_DEF = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Physical memory arbiter shared by the instruction and data caches.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no grant; all commands and resps low; picks next requester
// SERVE_I | instruction cache owns pmem until pmem_resp
// SERVE_D | data cache owns pmem until pmem_resp
//
// last_grant_q: 0 = I was served last, 1 = D was served last. It resets to
// 1 so the first simultaneous request goes to the instruction cache.
module pmem_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_read,
   input  logic [ADDR_WIDTH-1:0] i_address,
   output logic                  i_resp,
   output logic [LINE_WIDTH-1:0] i_rdata,
   input  logic                  d_read,
   input  logic                  d_write,
   input  logic [ADDR_WIDTH-1:0] d_address,
   input  logic [LINE_WIDTH-1:0] d_wdata,
   output logic                  d_resp,
   output logic [LINE_WIDTH-1:0] d_rdata,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic                  pmem_resp,
   input  logic [LINE_WIDTH-1:0] pmem_rdata
);

   arb_state_t state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic       d_req;

   assign d_req = d_read | d_write;

   // Next-state and fairness bookkeeping.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (i_read && d_req) begin
               // Alternate: whoever was not served last wins the tie.
               state_d = last_grant_q ? SERVE_I : SERVE_D;
            end else if (i_read) begin
               state_d = SERVE_I;
            end else if (d_req) begin
               state_d = SERVE_D;
            end
         end
         SERVE_I: begin
            if (pmem_resp) begin
               state_d      = IDLE;
               last_grant_d = 1'b0;
            end
         end
         SERVE_D: begin
            if (pmem_resp) begin
               state_d      = IDLE;
               last_grant_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and last-grant registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Output mux keyed on the current grant; resps pass pmem_resp through
   // in the same cycle so the cache sees completion without extra latency.
   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_resp       = 1'b0;
      d_resp       = 1'b0;
      i_rdata      = pmem_rdata;
      d_rdata      = pmem_rdata;
      case (state_q)
         SERVE_I: begin
            pmem_read    = i_read;
            pmem_address = i_address;
            i_resp       = pmem_resp;
         end
         SERVE_D: begin
            // A writeback takes precedence if both commands are raised.
            pmem_write   = d_write;
            pmem_read    = d_read & ~d_write;
            pmem_address = d_address;
            pmem_wdata   = d_wdata;
            d_resp       = pmem_resp;
         end
         default: ;
      endcase
   end

endmodule
